// File: rtl/mem_bus_bridge.sv
// ============================================================================
// Module   : mem_bus_bridge
// Purpose  : Single-outstanding core-to-memory bus bridge with wait timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_bridge #(
    parameter int TIMEOUT = 15,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_busy,
    output logic              core_done,
    output logic              core_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (core_req) begin
                    we_d    = core_we;
                    addr_d  = core_addr;
                    wdata_d = core_wdata;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // An ack on the final wait edge still completes cleanly.
                if (bus_ack) begin
                    state_d = S_DONE;
                    if (!we_q) rdata_d = bus_rdata;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_WAIT) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        if (!we_q) rdata_d = '1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Outputs decode directly from state so an async reset drops them at once.
    assign bus_req    = (state_q == S_BUSY);
    assign core_busy  = (state_q != S_IDLE);
    assign core_done  = (state_q == S_DONE);
    assign core_err   = (state_q == S_DONE) && err_q;
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign core_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_bridge.sv
// ============================================================================
// Module   : tb_mem_bus_bridge
// Purpose  : Directed self-checking bench for mem_bus_bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_bridge;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [15:0] core_addr = '0;
    logic [15:0] core_wdata = '0;
    logic [15:0] core_rdata;
    logic        core_busy, core_done, core_err;
    logic        bus_req, bus_we;
    logic [15:0] bus_addr, bus_wdata;
    logic [15:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    mem_bus_bridge #(.TIMEOUT(TIMEOUT), .ADDR_W(16), .DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_busy  (core_busy),
        .core_done  (core_done),
        .core_err   (core_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; on return the bridge is in its first BUSY cycle.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wd);
        core_req   = 1'b1;
        core_we    = we;
        core_addr  = addr;
        core_wdata = wd;
        tick();
        core_req = 1'b0;
    endtask

    initial begin
        int early;
        // Reset values
        tick();
        tick();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_busy", core_busy, 0);
        chk("rst_done", core_done, 0);
        chk("rst_err", core_err, 0);
        chk("rst_rdata", core_rdata, 16'h0000);
        chk("rst_addr", bus_addr, 16'h0000);
        chk("rst_wdata", bus_wdata, 16'h0000);
        chk("rst_we", bus_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Read, zero wait
        issue(1'b0, 16'h0010, 16'h0000);
        chk("rd0_bus_req", bus_req, 1);
        chk("rd0_addr", bus_addr, 16'h0010);
        chk("rd0_we", bus_we, 0);
        bus_ack = 1'b1;
        bus_rdata = 16'h1234;
        tick();
        bus_ack = 1'b0;
        chk("rd0_done", core_done, 1);
        chk("rd0_err", core_err, 0);
        chk("rd0_rdata", core_rdata, 16'h1234);
        chk("rd0_bus_req_off", bus_req, 0);
        chk("rd0_busy_done", core_busy, 1);
        tick();
        chk("rd0_done_1cyc", core_done, 0);
        chk("rd0_idle_busy", core_busy, 0);

        // bus_ack outside BUSY is ignored
        bus_ack = 1'b1;
        bus_rdata = 16'h7777;
        tick();
        bus_ack = 1'b0;
        chk("idle_ack_busy", core_busy, 0);
        chk("idle_ack_rdata", core_rdata, 16'h1234);

        // Write, 3 wait cycles
        issue(1'b1, 16'h0020, 16'hBEEF);
        for (int i = 0; i < 3; i++) begin
            chk("wr3_addr", bus_addr, 16'h0020);
            chk("wr3_wdata", bus_wdata, 16'hBEEF);
            chk("wr3_done_early", core_done, 0);
            tick();
        end
        chk("wr3_addr_last", bus_addr, 16'h0020);
        chk("wr3_we", bus_we, 1);
        chk("wr3_bus_req", bus_req, 1);
        bus_ack = 1'b1;
        bus_rdata = 16'h5555;
        tick();
        bus_ack = 1'b0;
        chk("wr3_done", core_done, 1);
        chk("wr3_err", core_err, 0);
        chk("wr3_rdata_kept", core_rdata, 16'h1234);
        tick();

        // Timeout on a read, ack never arrives
        issue(1'b0, 16'h0030, 16'h0000);
        early = 0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            if (core_done || !bus_req) early++;
            tick();
        end
        chk("to_no_early_done", early, 0);
        chk("to_done", core_done, 1);
        chk("to_err", core_err, 1);
        chk("to_rdata", core_rdata, 16'hFFFF);
        chk("to_bus_req", bus_req, 0);
        tick();
        chk("to_err_clear", core_err, 0);
        chk("to_idle", core_busy, 0);

        // Ack on the timeout edge wins
        issue(1'b0, 16'h0040, 16'h0000);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("tack_still_busy", bus_req, 1);
        bus_ack = 1'b1;
        bus_rdata = 16'hABCD;
        tick();
        bus_ack = 1'b0;
        chk("tack_done", core_done, 1);
        chk("tack_err", core_err, 0);
        chk("tack_rdata", core_rdata, 16'hABCD);
        tick();

        // core_req during BUSY is ignored
        issue(1'b0, 16'h0050, 16'h0000);
        core_req = 1'b1;
        core_addr = 16'h0099;
        tick();
        chk("busyreq_addr", bus_addr, 16'h0050);
        bus_ack = 1'b1;
        bus_rdata = 16'h1111;
        tick();
        bus_ack = 1'b0;
        core_req = 1'b0;
        chk("busyreq_done", core_done, 1);
        chk("busyreq_addr_done", bus_addr, 16'h0050);
        tick();
        chk("busyreq_no_second", bus_req, 0);
        tick();
        chk("busyreq_no_second2", core_busy, 0);

        // Back-to-back: request right after DONE
        issue(1'b0, 16'h0058, 16'h0000);
        bus_ack = 1'b1;
        bus_rdata = 16'h2222;
        tick();
        bus_ack = 1'b0;
        chk("b2b_done", core_done, 1);
        tick();
        issue(1'b1, 16'h0060, 16'hCAFE);
        chk("b2b_bus_req", bus_req, 1);
        chk("b2b_addr", bus_addr, 16'h0060);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("b2b_rdata_kept", core_rdata, 16'h2222);
        tick();

        // Asynchronous reset mid-BUSY
        issue(1'b0, 16'h0070, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bus_req", bus_req, 0);
        chk("arst_busy", core_busy, 0);
        chk("arst_done", core_done, 0);
        chk("arst_addr", bus_addr, 16'h0000);
        chk("arst_rdata", core_rdata, 16'h0000);
        tick();
        chk("arst_no_done", core_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        core_req = 1'b1;
        core_addr = 16'h0080;
        tick();
        core_req = 1'b0;
        chk("post_rst_accept", bus_req, 1);
        chk("post_rst_addr", bus_addr, 16'h0080);
        bus_ack = 1'b1;
        bus_rdata = 16'h3333;
        tick();
        bus_ack = 1'b0;
        chk("post_rst_rdata", core_rdata, 16'h3333);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
